// File: rtl/mem_port_arbiter.sv
// Two-client arbiter for the single main-memory port: four request slots
// (c0 write, c0 read, c1 write, c1 read) served round-robin, one transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] c0_mem_in_addr,
    input  logic [DATA_W-1:0] c0_mem_in_data,
    input  logic              c0_mem_in_valid,
    output logic              c0_mem_in_ready,
    input  logic [ADDR_W-1:0] c0_mem_out_addr,
    input  logic              c0_mem_out_valid,
    output logic [DATA_W-1:0] c0_mem_out_data,
    output logic              c0_mem_out_ready,

    input  logic [ADDR_W-1:0] c1_mem_in_addr,
    input  logic [DATA_W-1:0] c1_mem_in_data,
    input  logic              c1_mem_in_valid,
    output logic              c1_mem_in_ready,
    input  logic [ADDR_W-1:0] c1_mem_out_addr,
    input  logic              c1_mem_out_valid,
    output logic [DATA_W-1:0] c1_mem_out_data,
    output logic              c1_mem_out_ready,

    output logic [ADDR_W-1:0] main_mem_in_addr,
    output logic [DATA_W-1:0] main_mem_in_data,
    output logic              main_mem_in_valid,
    input  logic              main_mem_in_ready,
    output logic [ADDR_W-1:0] main_mem_out_addr,
    output logic              main_mem_out_valid,
    input  logic [DATA_W-1:0] main_mem_out_data,
    input  logic              main_mem_out_ready,

    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        ptr_reg;
    logic [1:0]        slot_reg;
    logic              busy_reg;
    logic [ADDR_W-1:0] in_addr_reg, out_addr_reg;
    logic [DATA_W-1:0] in_data_reg;
    logic              in_valid_reg, out_valid_reg;

    logic [3:0]        req;
    logic [ADDR_W-1:0] req_addr [4];
    logic [DATA_W-1:0] req_data [2];
    logic              grant_valid;
    logic [1:0]        grant_slot;
    logic [1:0]        scan_idx;
    logic              mem_done;
    logic              done_pulse;

    // Slot index bit 0 selects read (1) / write (0); bit 1 selects the client.
    assign req         = {c1_mem_out_valid, c1_mem_in_valid, c0_mem_out_valid, c0_mem_in_valid};
    assign req_addr[0] = c0_mem_in_addr;
    assign req_addr[1] = c0_mem_out_addr;
    assign req_addr[2] = c1_mem_in_addr;
    assign req_addr[3] = c1_mem_out_addr;
    assign req_data[0] = c0_mem_in_data;
    assign req_data[1] = c1_mem_in_data;

    // Scan from the farthest offset down so the slot nearest ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_slot  = ptr_reg;
        scan_idx    = ptr_reg;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = ptr_reg + 2'(i);
            if (req[scan_idx]) begin
                grant_valid = 1'b1;
                grant_slot  = scan_idx;
            end
        end
    end

    // Only the ready of the channel actually in use can complete a transaction.
    assign mem_done   = slot_reg[0] ? main_mem_out_ready : main_mem_in_ready;
    assign done_pulse = (state_reg == ISSUE) && mem_done;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   if (mem_done)    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= 2'd0;
            slot_reg      <= 2'd0;
            busy_reg      <= 1'b0;
            in_addr_reg   <= '0;
            in_data_reg   <= '0;
            in_valid_reg  <= 1'b0;
            out_addr_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            if (state_reg == IDLE && grant_valid) begin
                slot_reg <= grant_slot;
                ptr_reg  <= grant_slot + 2'd1;
                if (grant_slot[0]) begin
                    out_addr_reg  <= req_addr[grant_slot];
                    out_valid_reg <= 1'b1;
                end else begin
                    in_addr_reg  <= req_addr[grant_slot];
                    in_data_reg  <= req_data[grant_slot[1]];
                    in_valid_reg <= 1'b1;
                end
            end
            if (done_pulse) begin
                in_valid_reg  <= 1'b0;
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Per-client response registers; ready is a one-cycle pulse because it is
    // only set on the completing edge and cleared on every other edge.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_client
        logic              wr_ready_reg;
        logic              rd_ready_reg;
        logic [DATA_W-1:0] rd_data_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ready_reg <= 1'b0;
                rd_ready_reg <= 1'b0;
                rd_data_reg  <= '0;
            end else begin
                wr_ready_reg <= done_pulse && (slot_reg == 2'(2 * gi));
                rd_ready_reg <= done_pulse && (slot_reg == 2'(2 * gi + 1));
                if (done_pulse && (slot_reg == 2'(2 * gi + 1)))
                    rd_data_reg <= main_mem_out_data;
            end
        end
    end

    assign c0_mem_in_ready    = gen_client[0].wr_ready_reg;
    assign c0_mem_out_ready   = gen_client[0].rd_ready_reg;
    assign c0_mem_out_data    = gen_client[0].rd_data_reg;
    assign c1_mem_in_ready    = gen_client[1].wr_ready_reg;
    assign c1_mem_out_ready   = gen_client[1].rd_ready_reg;
    assign c1_mem_out_data    = gen_client[1].rd_data_reg;

    assign main_mem_in_addr   = in_addr_reg;
    assign main_mem_in_data   = in_data_reg;
    assign main_mem_in_valid  = in_valid_reg;
    assign main_mem_out_addr  = out_addr_reg;
    assign main_mem_out_valid = out_valid_reg;
    assign busy               = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory logs every
// completed grant and a monitor logs every client ready pulse.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] c0_mem_in_addr, c0_mem_in_data, c0_mem_out_addr, c0_mem_out_data;
    logic        c0_mem_in_valid, c0_mem_in_ready, c0_mem_out_valid, c0_mem_out_ready;
    logic [31:0] c1_mem_in_addr, c1_mem_in_data, c1_mem_out_addr, c1_mem_out_data;
    logic        c1_mem_in_valid, c1_mem_in_ready, c1_mem_out_valid, c1_mem_out_ready;
    logic [31:0] main_mem_in_addr, main_mem_in_data, main_mem_out_addr, main_mem_out_data;
    logic        main_mem_in_valid, main_mem_in_ready, main_mem_out_valid, main_mem_out_ready;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .c0_mem_in_addr(c0_mem_in_addr), .c0_mem_in_data(c0_mem_in_data),
        .c0_mem_in_valid(c0_mem_in_valid), .c0_mem_in_ready(c0_mem_in_ready),
        .c0_mem_out_addr(c0_mem_out_addr), .c0_mem_out_valid(c0_mem_out_valid),
        .c0_mem_out_data(c0_mem_out_data), .c0_mem_out_ready(c0_mem_out_ready),
        .c1_mem_in_addr(c1_mem_in_addr), .c1_mem_in_data(c1_mem_in_data),
        .c1_mem_in_valid(c1_mem_in_valid), .c1_mem_in_ready(c1_mem_in_ready),
        .c1_mem_out_addr(c1_mem_out_addr), .c1_mem_out_valid(c1_mem_out_valid),
        .c1_mem_out_data(c1_mem_out_data), .c1_mem_out_ready(c1_mem_out_ready),
        .main_mem_in_addr(main_mem_in_addr), .main_mem_in_data(main_mem_in_data),
        .main_mem_in_valid(main_mem_in_valid), .main_mem_in_ready(main_mem_in_ready),
        .main_mem_out_addr(main_mem_out_addr), .main_mem_out_valid(main_mem_out_valid),
        .main_mem_out_data(main_mem_out_data), .main_mem_out_ready(main_mem_out_ready),
        .busy(busy)
    );

    typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;
    typedef struct packed {logic [1:0] slot; logic [31:0] data;} resp_t;

    txn_t  exp_q[$], grant_q[$];
    resp_t exp_resp_q[$], resp_q[$];
    int    n_pass = 0, n_checks = 0;
    int    mem_delay = 1;
    int    mem_cnt = 0;
    int    double_high = 0;
    logic [3:0] prev_rdy = 4'b0;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : ~a;
    endfunction

    // Behavioural memory: raises ready mem_delay cycles after seeing valid.
    initial begin
        main_mem_in_ready  = 1'b0;
        main_mem_out_ready = 1'b0;
        main_mem_out_data  = 32'h0;
        forever begin
            @(negedge clk);
            main_mem_in_ready  = 1'b0;
            main_mem_out_ready = 1'b0;
            if (reset === 1'b1) mem_cnt = 0;
            else if (main_mem_in_valid === 1'b1 || main_mem_out_valid === 1'b1) begin
                mem_cnt++;
                if (mem_cnt >= mem_delay) begin
                    mem_cnt = 0;
                    if (main_mem_in_valid === 1'b1) begin
                        main_mem_in_ready = 1'b1;
                        grant_q.push_back({1'b1, main_mem_in_addr, main_mem_in_data});
                    end else begin
                        main_mem_out_ready = 1'b1;
                        main_mem_out_data  = rdata_of(main_mem_out_addr);
                        grant_q.push_back({1'b0, main_mem_out_addr, 32'h0});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] r;
        r = {c1_mem_out_ready, c1_mem_in_ready, c0_mem_out_ready, c0_mem_in_ready};
        for (int i = 0; i < 4; i++) begin
            if (r[i] === 1'b1) begin
                if (prev_rdy[i]) double_high++;
                resp_q.push_back({2'(i), (i == 1) ? c0_mem_out_data :
                                         (i == 3) ? c1_mem_out_data : 32'h0});
            end
        end
        prev_rdy = r;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (resp_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_queues();
        exp_q.delete(); grant_q.delete(); exp_resp_q.delete(); resp_q.delete();
    endtask

    // Drops each client valid on its ready pulse; ok once all are low and idle.
    task automatic serve_until_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (c0_mem_in_ready)  c0_mem_in_valid  = 1'b0;
            if (c0_mem_out_ready) c0_mem_out_valid = 1'b0;
            if (c1_mem_in_ready)  c1_mem_in_valid  = 1'b0;
            if (c1_mem_out_ready) c1_mem_out_valid = 1'b0;
            if (!(c0_mem_in_valid | c0_mem_out_valid | c1_mem_in_valid | c1_mem_out_valid)
                && !busy && !main_mem_in_valid && !main_mem_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({busy, main_mem_in_valid, main_mem_out_valid, c0_mem_in_ready, c0_mem_out_ready,
             c1_mem_in_ready, c1_mem_out_ready} !== 7'b0)
            $display("FAIL reset_flags: got %b expected 0", {busy, main_mem_in_valid,
                     main_mem_out_valid, c0_mem_in_ready, c0_mem_out_ready, c1_mem_in_ready,
                     c1_mem_out_ready});
        else n_pass++;
        n_checks++;
        if ({main_mem_in_addr, main_mem_in_data, main_mem_out_addr} !== 96'h0)
            $display("FAIL reset_main: got %h %h %h expected 0", main_mem_in_addr,
                     main_mem_in_data, main_mem_out_addr);
        else n_pass++;
        n_checks++;
        if ({c0_mem_out_data, c1_mem_out_data} !== 64'h0)
            $display("FAIL reset_rdata: got %h %h expected 0", c0_mem_out_data, c1_mem_out_data);
        else n_pass++;
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        bit ok;
        clear_queues();
        mem_delay = 2;
        exp_q.push_back({1'b0, 32'h40, 32'h0});
        exp_resp_q.push_back({2'd3, 32'hDEADBEEF});
        c1_mem_out_addr = 32'h40; c1_mem_out_valid = 1'b1;
        tick();
        n_checks++;
        if ({main_mem_out_valid, main_mem_in_valid, main_mem_out_addr} !== {2'b10, 32'h40})
            $display("FAIL read_issue: got v=%b/%b addr=%h expected 1/0 00000040",
                     main_mem_out_valid, main_mem_in_valid, main_mem_out_addr);
        else n_pass++;
        wait_resp(1, 20, ok);
        c1_mem_out_valid = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (!ok || grant_q.size() != 1 || resp_q.size() != 1)
            $display("FAIL read_counts: got grants=%0d resps=%0d expected 1 1", grant_q.size(), resp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && grant_q.size() > 0) begin
            txn_t e = exp_q.pop_front(); txn_t g = grant_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL read_grant: got %h expected %h", g, e); else n_pass++;
        end
        while (exp_resp_q.size() > 0 && resp_q.size() > 0) begin
            resp_t e = exp_resp_q.pop_front(); resp_t g = resp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL read_resp: got %h expected %h", g, e); else n_pass++;
        end
        n_checks++;
        if (c0_mem_out_data !== 32'h0 || double_high != 0)
            $display("FAIL read_side: got c0_data=%h double=%0d expected 0 0", c0_mem_out_data, double_high);
        else n_pass++;
        $display("test_single_read done");
    endtask

    task automatic test_single_write();
        bit ok;
        clear_queues();
        mem_delay = 3;
        exp_q.push_back({1'b1, 32'h10, 32'h1234});
        exp_resp_q.push_back({2'd0, 32'h0});
        c0_mem_in_addr = 32'h10; c0_mem_in_data = 32'h1234; c0_mem_in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({main_mem_in_valid, main_mem_out_valid, main_mem_in_addr, main_mem_in_data}
                !== {2'b10, 32'h10, 32'h1234})
                $display("FAIL write_hold: got v=%b/%b %h %h expected 1/0 00000010 00001234",
                         main_mem_in_valid, main_mem_out_valid, main_mem_in_addr, main_mem_in_data);
            else n_pass++;
        end
        wait_resp(1, 20, ok);
        c0_mem_in_valid = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (!ok || grant_q.size() != 1 || resp_q.size() != 1)
            $display("FAIL write_counts: got grants=%0d resps=%0d expected 1 1", grant_q.size(), resp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && grant_q.size() > 0) begin
            txn_t e = exp_q.pop_front(); txn_t g = grant_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL write_grant: got %h expected %h", g, e); else n_pass++;
        end
        while (exp_resp_q.size() > 0 && resp_q.size() > 0) begin
            resp_t e = exp_resp_q.pop_front(); resp_t g = resp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL write_resp: got %h expected %h", g, e); else n_pass++;
        end
        n_checks++;
        if (c1_mem_out_data !== 32'hDEADBEEF || double_high != 0)
            $display("FAIL write_side: got c1_data=%h double=%0d expected deadbeef 0", c1_mem_out_data, double_high);
        else n_pass++;
        $display("test_single_write done");
    endtask

    task automatic test_input_change();
        bit ok;
        clear_queues();
        mem_delay = 3;
        exp_q.push_back({1'b1, 32'h10, 32'h55});
        c0_mem_in_addr = 32'h10; c0_mem_in_data = 32'h55; c0_mem_in_valid = 1'b1;
        tick();
        c0_mem_in_addr = 32'h20; c0_mem_in_data = 32'h66;
        tick();
        n_checks++;
        if ({main_mem_in_addr, main_mem_in_data} !== {32'h10, 32'h55})
            $display("FAIL change_hold: got %h %h expected 00000010 00000055", main_mem_in_addr, main_mem_in_data);
        else n_pass++;
        serve_until_idle(30, ok);
        n_checks++;
        if (!ok || grant_q.size() != 1) $display("FAIL change_count: got ok=%b grants=%0d expected 1 1", ok, grant_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && grant_q.size() > 0) begin
            txn_t e = exp_q.pop_front(); txn_t g = grant_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL change_grant: got %h expected %h", g, e); else n_pass++;
        end
        $display("test_input_change done");
    endtask

    task automatic test_contention();
        bit ok;
        reset = 1'b1;
        clear_queues();
        tick();
        mem_delay = 1;
        c0_mem_in_addr  = 32'h100; c0_mem_in_data = 32'hA0; c0_mem_in_valid  = 1'b1;
        c0_mem_out_addr = 32'h104;                          c0_mem_out_valid = 1'b1;
        c1_mem_in_addr  = 32'h200; c1_mem_in_data = 32'hB0; c1_mem_in_valid  = 1'b1;
        c1_mem_out_addr = 32'h204;                          c1_mem_out_valid = 1'b1;
        exp_q.push_back({1'b1, 32'h100, 32'hA0});
        exp_q.push_back({1'b0, 32'h104, 32'h0});
        exp_q.push_back({1'b1, 32'h200, 32'hB0});
        exp_q.push_back({1'b0, 32'h204, 32'h0});
        exp_resp_q.push_back({2'd0, 32'h0});
        exp_resp_q.push_back({2'd1, rdata_of(32'h104)});
        exp_resp_q.push_back({2'd2, 32'h0});
        exp_resp_q.push_back({2'd3, rdata_of(32'h204)});
        tick();
        reset = 1'b0;
        serve_until_idle(80, ok);
        repeat (3) tick();
        n_checks++;
        if (!ok || grant_q.size() != 4 || resp_q.size() != 4 || double_high != 0)
            $display("FAIL contention_counts: got ok=%b grants=%0d resps=%0d double=%0d expected 1 4 4 0",
                     ok, grant_q.size(), resp_q.size(), double_high);
        else n_pass++;
        while (exp_q.size() > 0 && grant_q.size() > 0) begin
            txn_t e = exp_q.pop_front(); txn_t g = grant_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL contention_grant: got %h expected %h", g, e); else n_pass++;
        end
        while (exp_resp_q.size() > 0 && resp_q.size() > 0) begin
            resp_t e = exp_resp_q.pop_front(); resp_t g = resp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL contention_resp: got %h expected %h", g, e); else n_pass++;
        end
        $display("test_contention done");
    endtask

    task automatic test_fairness();
        bit ok;
        int pos;
        clear_queues();
        mem_delay = 1;
        c0_mem_out_addr = 32'h300; c0_mem_out_valid = 1'b1;
        c1_mem_in_addr  = 32'h310; c1_mem_in_data = 32'h77; c1_mem_in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (c1_mem_in_ready) begin
                c1_mem_in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        c0_mem_out_valid = 1'b0;
        pos = -1;
        for (int i = grant_q.size() - 1; i >= 0; i--)
            if (grant_q[i].wr) pos = i;
        n_checks++;
        if (!ok || pos < 0 || pos > 1)
            $display("FAIL fairness: got write at grant %0d (done=%b) expected 0 or 1", pos, ok);
        else n_pass++;
        serve_until_idle(30, ok);
        n_checks++;
        if (!ok) $display("FAIL fairness_idle: got busy=%b expected 0", busy); else n_pass++;
        $display("test_fairness done");
    endtask

    task automatic test_reset_issue();
        bit ok;
        clear_queues();
        mem_delay = 1000;
        c0_mem_out_addr = 32'h80; c0_mem_out_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (main_mem_out_valid) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL rst_issue_start: got out_valid=%b expected 1", main_mem_out_valid);
        else n_pass++;
        c1_mem_in_addr = 32'h90; c1_mem_in_data = 32'h99; c1_mem_in_valid = 1'b1;
        tick();
        reset = 1'b1;
        mem_delay = 1;
        tick();
        n_checks++;
        if ({busy, main_mem_in_valid, main_mem_out_valid, c0_mem_in_ready, c0_mem_out_ready,
             c1_mem_in_ready, c1_mem_out_ready} !== 7'b0 || c1_mem_out_data !== 32'h0)
            $display("FAIL rst_issue_abort: got busy=%b v=%b/%b c1_data=%h expected 0 0/0 0",
                     busy, main_mem_in_valid, main_mem_out_valid, c1_mem_out_data);
        else n_pass++;
        reset = 1'b0;
        exp_q.push_back({1'b0, 32'h80, 32'h0});
        exp_q.push_back({1'b1, 32'h90, 32'h99});
        exp_resp_q.push_back({2'd1, rdata_of(32'h80)});
        exp_resp_q.push_back({2'd2, 32'h0});
        serve_until_idle(60, ok);
        n_checks++;
        if (!ok || grant_q.size() != 2 || resp_q.size() != 2)
            $display("FAIL rst_issue_counts: got ok=%b grants=%0d resps=%0d expected 1 2 2",
                     ok, grant_q.size(), resp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && grant_q.size() > 0) begin
            txn_t e = exp_q.pop_front(); txn_t g = grant_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL rst_issue_grant: got %h expected %h", g, e); else n_pass++;
        end
        while (exp_resp_q.size() > 0 && resp_q.size() > 0) begin
            resp_t e = exp_resp_q.pop_front(); resp_t g = resp_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL rst_issue_resp: got %h expected %h", g, e); else n_pass++;
        end
        $display("test_reset_issue done");
    endtask

    initial begin
        reset = 1'b1;
        c0_mem_in_addr = '0; c0_mem_in_data = '0; c0_mem_in_valid = 1'b0;
        c0_mem_out_addr = '0; c0_mem_out_valid = 1'b0;
        c1_mem_in_addr = '0; c1_mem_in_data = '0; c1_mem_in_valid = 1'b0;
        c1_mem_out_addr = '0; c1_mem_out_valid = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_input_change();
        test_contention();
        test_fairness();
        test_reset_issue();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
